// File: rtl/display_regs_pkg.sv
// -----------------------------------------------------------------------------
// display_regs_pkg
// Shared display defines: seven-segment codes (active-low, bit 6 = segment g,
// bit 0 = segment a), LEDR bar constants and a nibble-to-segment helper used by
// the sequencer that feeds display_regs.
// No ports (package).
// -----------------------------------------------------------------------------
package display_regs_pkg;

   typedef logic [6:0] seg_t;
   typedef logic [9:0] ledr_t;

   localparam int HEX_DIGITS = 6;

   // Active-low segment codes: a 0 lights the segment.
   localparam seg_t HEX_0   = 7'h40;
   localparam seg_t HEX_1   = 7'h79;
   localparam seg_t HEX_2   = 7'h24;
   localparam seg_t HEX_3   = 7'h30;
   localparam seg_t HEX_4   = 7'h19;
   localparam seg_t HEX_5   = 7'h12;
   localparam seg_t HEX_6   = 7'h02;
   localparam seg_t HEX_7   = 7'h78;
   localparam seg_t HEX_8   = 7'h00;
   localparam seg_t HEX_9   = 7'h10;
   localparam seg_t HEX_A   = 7'h08;
   localparam seg_t HEX_B   = 7'h03;
   localparam seg_t HEX_C   = 7'h46;
   localparam seg_t HEX_D   = 7'h21;
   localparam seg_t HEX_E   = 7'h06;
   localparam seg_t HEX_F   = 7'h0E;
   localparam seg_t HEX_OFF = 7'h7F;

   // LEDR bar: all off, and all ten lit (the last position before wrapping).
   localparam ledr_t LEDR_OFF = 10'h000;
   localparam ledr_t LEDR_10  = 10'h3FF;

   function automatic seg_t hex_digit(input logic [3:0] value);
      seg_t code;
      case (value)
         4'h0:    code = HEX_0;
         4'h1:    code = HEX_1;
         4'h2:    code = HEX_2;
         4'h3:    code = HEX_3;
         4'h4:    code = HEX_4;
         4'h5:    code = HEX_5;
         4'h6:    code = HEX_6;
         4'h7:    code = HEX_7;
         4'h8:    code = HEX_8;
         4'h9:    code = HEX_9;
         4'hA:    code = HEX_A;
         4'hB:    code = HEX_B;
         4'hC:    code = HEX_C;
         4'hD:    code = HEX_D;
         4'hE:    code = HEX_E;
         default: code = HEX_F;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/display_regs_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Divides clk down to one display step every TICK_DIV cycles (TICK_DIV >= 2).
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   pause  in   holds the count and suppresses step while high
//   step   out  one-clk pulse, registered
// The terminal count is decoded together with pause and registered, so step
// rises the clk after the counter sat at TICK_DIV-1 with pause low. A pause
// sampled while the count is at TICK_DIV-1 therefore cancels that step and
// parks the counter at TICK_DIV-1 until pause drops.
// -----------------------------------------------------------------------------
module tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic pause,
   output logic step
);

   localparam int               CNT_W   = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_p0;
   logic             step_p0;
   logic             at_max;

   // Full-width compare against the terminal count.
   assign at_max = (cnt_p0 == CNT_MAX);

   // Stage p0: counter and registered step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_p0  <= '0;
         step_p0 <= 1'b0;
      end else begin
         step_p0 <= !pause && at_max;
         if (!pause) begin
            cnt_p0 <= at_max ? '0 : cnt_p0 + CNT_W'(1);
         end
      end
   end

   assign step = step_p0;

endmodule

// File: rtl/display_regs.sv
// -----------------------------------------------------------------------------
// display_regs
// Display output registers for the LEDR bar and HEX0..HEX5, advanced once per
// display step. The external sequencer advances on step and receives
// current_ledr / current_hex0..5 back as its state.
// Ports:
//   clk, reset          clock, asynchronous active-low reset (release must
//                       already be synchronous to clk)
//   pause               freezes stepping while high
//   ledr_en             advance the LEDR bar on the next step
//   hex_en              load next_hex0..5 on the next step
//   next_hex0..5        candidate segment codes from the sequencer
//   step                one-clk step pulse (registered)
//   current_ledr        registered LEDR bar
//   current_hex0..5     registered active-low segment codes for HEX0..HEX5
// -----------------------------------------------------------------------------
module display_regs
   import display_regs_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pause,
   input  logic       ledr_en,
   input  logic       hex_en,
   input  logic [6:0] next_hex0,
   input  logic [6:0] next_hex1,
   input  logic [6:0] next_hex2,
   input  logic [6:0] next_hex3,
   input  logic [6:0] next_hex4,
   input  logic [6:0] next_hex5,
   output logic       step,
   output logic [9:0] current_ledr,
   output logic [6:0] current_hex0,
   output logic [6:0] current_hex1,
   output logic [6:0] current_hex2,
   output logic [6:0] current_hex3,
   output logic [6:0] current_hex4,
   output logic [6:0] current_hex5
);

   // Bar grows by one lit LED per step; once all ten are lit it clears.
   function automatic ledr_t ledr_advance(input ledr_t cur);
      if (cur == LEDR_10) begin
         return LEDR_OFF;
      end
      return {cur[8:0], 1'b1};
   endfunction

   logic step_p0;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .pause (pause),
      .step  (step_p0)
   );

   assign step = step_p0;

   // Stage p1: display registers, updated on the clk where step is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         current_ledr <= LEDR_OFF;
      end else if (step_p0 && ledr_en) begin
         current_ledr <= ledr_advance(current_ledr);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         current_hex0 <= HEX_OFF;
         current_hex1 <= HEX_OFF;
         current_hex2 <= HEX_OFF;
         current_hex3 <= HEX_OFF;
         current_hex4 <= HEX_OFF;
         current_hex5 <= HEX_OFF;
      end else if (step_p0 && hex_en) begin
         current_hex0 <= next_hex0;
         current_hex1 <= next_hex1;
         current_hex2 <= next_hex2;
         current_hex3 <= next_hex3;
         current_hex4 <= next_hex4;
         current_hex5 <= next_hex5;
      end
   end

endmodule

// File: doc/display_regs.md
DISPLAY_REGS -- requirements
Module: display_regs

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clk and reset, with reset asserted when low.
REQ-002 Parameter TICK_DIV, default 50_000_000: clk cycles per display step (1 Hz at 50 MHz); legal range 2 and up.
REQ-003 Ports SHALL be, in order:
- clk  in  1  system clock
- reset  in  1  async active-low reset
- pause  in  1  freezes stepping while high
- ledr_en  in  1  advance LEDR bar on step
- hex_en  in  1  load next_hex0..5 on step
- next_hex0..next_hex5  in  7 each  candidate segment codes from the sequencer
- step  out  1  one-clk pulse per display step; the sequencer's advance enable
- current_ledr  out  10  registered LEDR bar
- current_hex0..current_hex5  out  7 each  registered segment codes, active-low, driving HEX0..HEX5

Function
REQ-004 Tick counter SHALL count 0..TICK_DIV-1 on every clk with pause low, wrap to 0, and assert step for exactly the one clk in which it equals TICK_DIV-1.
REQ-005 While pause is high, the counter SHALL hold its value and step SHALL be 0; counting SHALL resume from the held value.
REQ-006 If pause rises in the cycle the count reaches TICK_DIV-1, pause SHALL win: no step pulse and the counter holds at TICK_DIV-1.
REQ-007 Counter width SHALL be $clog2(TICK_DIV), and the wrap comparison SHALL use the full width with no truncation.
REQ-008 On a clk with step=1 and hex_en=1, current_hexN SHALL take next_hexN for all N simultaneously, with one-clk latency; otherwise all current_hexN SHALL hold.
REQ-009 On a clk with step=1 and ledr_en=1, current_ledr SHALL shift left one place with a 1 entering bit 0: 0x000, 0x001, 0x003, and so on up to 0x3FF (LEDR_10).
REQ-010 If current_ledr equals LEDR_10 on a ledr_en step, current_ledr SHALL wrap to 0x000 instead of shifting.
REQ-011 If ledr_en and hex_en are both high on a step, both updates SHALL occur in the same clk.
REQ-012 ledr_en and hex_en SHALL be ignored on clks with step=0, and next_hexN values between steps SHALL have no effect.
REQ-013 step and all current_* outputs SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-014 While reset is low: counter=0, step=0, current_ledr=0x000, and every current_hexN=HEX_OFF (7'b1111111), all taking effect asynchronously.
REQ-015 Reset asserted mid-count or mid-step SHALL abort the operation; after release, the first step SHALL occur exactly TICK_DIV clks later.
REQ-016 Reset release SHALL be synchronous to clk at the block boundary; the block does not synchronise it internally.

Structure
REQ-017 HEX_OFF, LEDR_10 and LEDR_OFF (0x000) SHALL live in the shared defines.sv alongside the existing HEX_* segment codes; the block SHALL contain no literal segment codes.
REQ-018 The tick counter SHALL be a sub-module tick_gen(clk, reset, pause, step) parameterised by TICK_DIV; display_regs instantiates it once.
REQ-019 The sequencer's state register SHALL advance only on step, and current_ledr and current_hex0..5 SHALL be fed back to its inputs.

Verification
REQ-020 Run the bench with TICK_DIV=4 and cover these scenarios:
- Reset low, then released -> all hex=7'h7F and ledr=0; step first high on clk 4 after release, then every 4 clks.
- hex_en=1 and next_hex0=7'h46 (C) on a step clk -> current_hex0=7'h46 the next clk; a hex_en pulse on a non-step clk -> no change.
- ledr_en held high for 11 steps -> ledr sequence 0x001, 0x003, ..., 0x3FF, then 0x000.
- pause raised at count 2 for 5 clks -> no step during pause; the next step occurs 2 clks after pause falls.
- pause rising in the same clk the count reaches 3 -> no step pulse; ledr and hex unchanged.
- Reset pulsed low at count 3 with ledr=0x07F -> ledr=0x000 and hex=7'h7F immediately; next step 4 clks after release.
